mem_access_unit: RTL and testbench

//  Load/store initiator that drives the word-organised data RAM port on behalf of the pipeline.

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mau_read_assemble.sv | 41 ++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store initiator: request sizes, RAM mode codes, FSM states.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeBad  = 2'd3
    } req_size_e;

    typedef enum logic [1:0] {
        ModeByte = 2'd0,
        ModeHalf = 2'd1,
        ModeWord = 2'd2
    } mem_mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBeat = 2'd1,
        StDone = 2'd2
    } state_e;

    // Accesses the word-organised RAM cannot serve in a single beat.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == SizeHalf && offset == 2'd3) || (size == SizeWord && offset != 2'd0);
    endfunction

endpackage

// File: rtl/mau_read_assemble.sv
// Collects load bytes from split beats and produces the final, extended load result.
module mau_read_assemble
    import mem_access_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        capture_i,
    input  logic [1:0]  beat_i,
    input  logic [7:0]  mem_byte_i,
    input  logic        native_i,
    input  logic [31:0] native_data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] rdata_o
);

    logic [3:0][7:0] bytes_q;
    logic [3:0][7:0] merged;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bytes_q <= '0;
        end else if (capture_i) begin
            bytes_q[beat_i] <= mem_byte_i;
        end
    end

    // The current beat's byte is merged in so the result is ready at the edge ending the last beat.
    always_comb begin
        merged         = bytes_q;
        merged[beat_i] = mem_byte_i;
        if (native_i) begin
            rdata_o = native_data_i;
        end else if (size_i == SizeHalf) begin
            rdata_o = {{16{signed_i & merged[1][7]}}, merged[1], merged[0]};
        end else begin
            rdata_o = merged;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and the word-organised data RAM; splits
// misaligned accesses into byte beats and returns a one-cycle response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_r_addr_o,
    output logic [31:0] mem_w_addr_o,
    output logic [31:0] mem_w_data_o,
    output logic [1:0]  mem_write_mode_o,
    output logic [1:0]  mem_read_mode_o,
    output logic        mem_read_signed_o,
    input  logic [31:0] mem_r_data_i
);

    state_e      state_q;
    logic [1:0]  beat_q;
    logic [1:0]  last_beat_q;
    logic        split_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_mis;
    logic        req_bad;
    logic [31:0] asm_rdata;

    assign req_mis = is_misaligned(req_size_i, req_addr_i[1:0]);
    assign req_bad = (req_size_i == SizeBad) || (req_mis && !SPLIT_MISALIGNED);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            beat_q       <= 2'd0;
            last_beat_q  <= 2'd0;
            split_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= SizeWord;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q     <= req_we_i;
                        size_q   <= req_size_i;
                        signed_q <= req_signed_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        beat_q   <= 2'd0;
                        if (req_bad) begin
                            state_q      <= StDone;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= StBeat;
                            resp_err_q  <= 1'b0;
                            split_q     <= req_mis;
                            last_beat_q <= !req_mis ? 2'd0 :
                                           (req_size_i == SizeHalf) ? 2'd1 : 2'd3;
                        end
                    end
                end
                StBeat: begin
                    if (beat_q == last_beat_q) begin
                        state_q      <= StDone;
                        resp_rdata_q <= we_q ? 32'd0 : asm_rdata;
                    end else begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    mau_read_assemble u_read_assemble (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .capture_i     ((state_q == StBeat) && split_q && !we_q),
        .beat_i        (beat_q),
        .mem_byte_i    (mem_r_data_i[7:0]),
        .native_i      (!split_q),
        .native_data_i (mem_r_data_i),
        .size_i        (size_q),
        .signed_i      (signed_q),
        .rdata_o       (asm_rdata)
    );

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StDone);
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    always_comb begin
        mem_we_o          = 1'b0;
        mem_r_addr_o      = '0;
        mem_w_addr_o      = '0;
        mem_w_data_o      = '0;
        mem_write_mode_o  = ModeWord;
        mem_read_mode_o   = ModeWord;
        mem_read_signed_o = 1'b0;
        if (state_q == StBeat) begin
            mem_r_addr_o = addr_q + {30'd0, beat_q};
            mem_w_addr_o = addr_q + {30'd0, beat_q};
            // A write must never reach the RAM in the cycle reset is asserted.
            mem_we_o     = we_q && !rst_i;
            if (split_q) begin
                mem_write_mode_o = ModeByte;
                mem_read_mode_o  = ModeByte;
                mem_w_data_o     = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
            end else begin
                mem_write_mode_o  = size_q;
                mem_read_mode_o   = size_q;
                mem_w_data_o      = wdata_q;
                mem_read_signed_o = signed_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-array RAM model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd2;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] mem_r_data = '0;

    logic        a_ready, a_rvalid, a_err, a_we, a_rsgn;
    logic [31:0] a_rdata, a_raddr, a_waddr, a_wdata;
    logic [1:0]  a_wmode, a_rmode;
    logic        b_ready, b_rvalid, b_err, b_we, b_rsgn;
    logic [31:0] b_rdata, b_raddr, b_waddr, b_wdata;
    logic [1:0]  b_wmode, b_rmode;

    logic [7:0]  ram [0:1023];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [7:0]  bd_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (valid_a), .req_ready_o (a_ready), .req_we_i (req_we),
        .req_size_i (req_size), .req_signed_i (req_signed), .req_addr_i (req_addr),
        .req_wdata_i (req_wdata), .resp_valid_o (a_rvalid), .resp_rdata_o (a_rdata),
        .resp_err_o (a_err), .mem_we_o (a_we), .mem_r_addr_o (a_raddr),
        .mem_w_addr_o (a_waddr), .mem_w_data_o (a_wdata), .mem_write_mode_o (a_wmode),
        .mem_read_mode_o (a_rmode), .mem_read_signed_o (a_rsgn), .mem_r_data_i (mem_r_data)
    );

    mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) u_dut_nosplit (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (valid_b), .req_ready_o (b_ready), .req_we_i (req_we),
        .req_size_i (req_size), .req_signed_i (req_signed), .req_addr_i (req_addr),
        .req_wdata_i (req_wdata), .resp_valid_o (b_rvalid), .resp_rdata_o (b_rdata),
        .resp_err_o (b_err), .mem_we_o (b_we), .mem_r_addr_o (b_raddr),
        .mem_w_addr_o (b_waddr), .mem_w_data_o (b_wdata), .mem_write_mode_o (b_wmode),
        .mem_read_mode_o (b_rmode), .mem_read_signed_o (b_rsgn), .mem_r_data_i (mem_r_data)
    );

    logic [9:0] wa, ra;
    assign wa = a_waddr[9:0];
    assign ra = a_raddr[9:0];

    // RAM model: writes on posedge, read data registered on negedge.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (a_we) begin
            ram[wa] <= a_wdata[7:0];
            if (a_wmode != 2'd0) ram[wa + 10'd1] <= a_wdata[15:8];
            if (a_wmode == 2'd2) begin
                ram[wa + 10'd2] <= a_wdata[23:16];
                ram[wa + 10'd3] <= a_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        case (a_rmode)
            2'd0:    mem_r_data <= {{24{a_rsgn & ram[ra][7]}}, ram[ra]};
            2'd1:    mem_r_data <= {{16{a_rsgn & ram[ra + 10'd1][7]}}, ram[ra + 10'd1], ram[ra]};
            default: mem_r_data <= {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]};
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [9:0] addr, input logic [7:0] data);
        bd_we   = 1'b1;
        bd_addr = addr;
        bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Issue one request and check latency (cycles after acceptance), data, error and store beats.
    task automatic request(input bit use_b, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input int exp_beats, input string tag);
        int guard = 0;
        int lat = 0;
        int beats = 0;
        logic [31:0] rdata = 32'hxxxx_xxxx;
        logic        err = 1'bx;
        while (!(use_b ? b_ready : a_ready) && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        valid_a    = !use_b;
        valid_b    = use_b;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (use_b ? b_we : a_we) beats++;
            if (use_b ? b_rvalid : a_rvalid) begin
                lat   = i;
                rdata = use_b ? b_rdata : a_rdata;
                err   = use_b ? b_err : a_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_rdata"}, rdata, exp_rdata);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_we_beats"}, 32'(beats), 32'(exp_beats));
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(a_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(a_rvalid), 32'd0);
        check_eq("rst_mem_we", 32'(a_we), 32'd0);
        check_eq("rst_rdata", a_rdata, 32'd0);
        check_eq("rst_modes", {28'd0, a_wmode, a_rmode}, 32'h0000_000a);
        check_eq("rst_raddr", a_raddr, 32'd0);
        check_eq("rst_rsgn", 32'(a_rsgn), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: aligned word store/load
        request(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 1, "st_w100");
        request(0, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0, "ld_w100");
        // 2: native byte loads with RAM-side extension
        request(0, 1, 2'd2, 0, 32'h100, 32'h80FF0000, 32'h0, 0, 2, 1, "st_w100b");
        request(0, 0, 2'd0, 1, 32'h103, 32'h0, 32'hFFFFFF80, 0, 2, 0, "ld_bs103");
        request(0, 0, 2'd0, 0, 32'h103, 32'h0, 32'h00000080, 0, 2, 0, "ld_bu103");
        // 3: split word store/load
        request(0, 1, 2'd2, 0, 32'h101, 32'h11223344, 32'h0, 0, 5, 4, "st_w101");
        check_eq("ram_101", 32'(ram[10'h101]), 32'h44);
        check_eq("ram_102", 32'(ram[10'h102]), 32'h33);
        check_eq("ram_103", 32'(ram[10'h103]), 32'h22);
        check_eq("ram_104", 32'(ram[10'h104]), 32'h11);
        request(0, 0, 2'd2, 0, 32'h101, 32'h0, 32'h11223344, 0, 5, 0, "ld_w101");
        request(0, 0, 2'd1, 0, 32'h101, 32'h0, 32'h00003344, 0, 2, 0, "ld_hu101");
        // 4: split half loads
        request(0, 1, 2'd0, 0, 32'h103, 32'h000000F34, 32'h0, 0, 2, 1, "st_b103");
        request(0, 1, 2'd0, 0, 32'h104, 32'h00000092, 32'h0, 0, 2, 1, "st_b104");
        request(0, 0, 2'd1, 1, 32'h103, 32'h0, 32'hFFFF9234, 0, 3, 0, "ld_hs103");
        request(0, 0, 2'd1, 0, 32'h103, 32'h0, 32'h00009234, 0, 3, 0, "ld_hu103");
        // 5: rejected misaligned and illegal sizes
        request(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1, 1, 0, "ns_ld_w102");
        request(1, 1, 2'd2, 0, 32'h102, 32'h55555555, 32'h0, 1, 1, 0, "ns_st_w102");
        request(1, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, "ns_size3");
        request(0, 1, 2'd3, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 1, 1, 0, "sp_size3");
        check_eq("ram_100_kept", 32'(ram[10'h100]), 32'h00);

        // 6: reset during the third beat of a split store
        for (int i = 1; i <= 4; i++) bd_write(10'(10'h100 + i), 8'h00);
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h101;
        req_wdata = 32'hAABBCCDD;
        valid_a   = 1'b1;
        @(posedge clk);
        #1 valid_a = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_eq("abort_mem_we_in_rst", 32'(a_we), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("abort_ready", 32'(a_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_rvalid) seen++;
            @(posedge clk);
            #1;
        end
        check_eq("abort_no_resp", 32'(seen), 32'd0);
        check_eq("abort_ram_101", 32'(ram[10'h101]), 32'hDD);
        check_eq("abort_ram_102", 32'(ram[10'h102]), 32'hCC);
        check_eq("abort_ram_103", 32'(ram[10'h103]), 32'h00);
        check_eq("abort_ram_104", 32'(ram[10'h104]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
